// File: rtl/openmips_pkg.sv
// Shared register-file widths and the write-back entry type.
// Also holds the hard-wired zero register index.
package openmips_pkg;
    localparam int REG_W   = 32;
    localparam int RADDR_W = 5;
    localparam logic [RADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [RADDR_W-1:0] waddr;
        logic [REG_W-1:0]   wdata;
    } wb_entry_t;
endpackage

// File: rtl/wb_ret_fifo.sv
// Write-back queue storage: circular buffer with occupancy count.
// Every slot and its valid bit are exposed so the top can run forwarding lookups.
module wb_ret_fifo
    import openmips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = REG_W,
    parameter int AW    = RADDR_W,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [AW-1:0]             push_waddr,
    input  logic [DW-1:0]             push_wdata,
    output logic                      full,
    output logic                      empty,
    output logic [PW-1:0]             rd_ptr,
    output logic [DEPTH-1:0][AW-1:0]  ent_waddr,
    output logic [DEPTH-1:0][DW-1:0]  ent_wdata,
    output logic [DEPTH-1:0]          ent_valid
);
    logic [DEPTH-1:0][AW-1:0] waddr_mem_reg;
    logic [DEPTH-1:0][DW-1:0] wdata_mem_reg;
    logic [PW-1:0]            rd_ptr_reg;
    logic [PW-1:0]            wr_ptr_reg;
    logic [CW-1:0]            count_reg;
    logic [CW-1:0]            count_next;

    // Slot contents are deliberately not reset; the valid mask gates them.
    always_ff @(posedge clk) begin
        if (push) begin
            waddr_mem_reg[wr_ptr_reg] <= push_waddr;
            wdata_mem_reg[wr_ptr_reg] <= push_wdata;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_next;
        end
    end

    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign rd_ptr    = rd_ptr_reg;
    assign ent_waddr = waddr_mem_reg;
    assign ent_wdata = wdata_mem_reg;

    // A slot is live when its distance from the head is below the occupancy.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_valid
            logic [PW-1:0] age;
            assign age           = PW'(gi) - rd_ptr_reg;
            assign ent_valid[gi] = (CW'(age) < count_reg);
        end
    endgenerate
endmodule

// File: rtl/wb_ret_buf.sv
// Write-back return buffer: queues MEM results, drains one per cycle into the
// regfile write port, and forwards uncommitted values to ID's two operand reads.
module wb_ret_buf
    import openmips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = REG_W,
    parameter int AW    = RADDR_W
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          mem_o_wreg,
    input  logic [AW-1:0] mem_o_waddr,
    input  logic [DW-1:0] mem_o_wdata,
    output logic          stall_req,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    input  logic          rf_ready,
    input  logic [AW-1:0] id_raddr0,
    input  logic [DW-1:0] id_rf_data0,
    output logic [DW-1:0] id_reg0,
    input  logic [AW-1:0] id_raddr1,
    input  logic [DW-1:0] id_rf_data1,
    output logic [DW-1:0] id_reg1
);
    localparam int PW = $clog2(DEPTH);

    logic                     push_req;
    logic                     push;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic [PW-1:0]            rd_ptr;
    logic [DEPTH-1:0][AW-1:0] ent_waddr;
    logic [DEPTH-1:0][DW-1:0] ent_wdata;
    logic [DEPTH-1:0]         ent_valid;

    wb_ret_fifo #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_fifo (
        .clk        (clk),
        .srst       (rst_),
        .push       (push),
        .pop        (pop),
        .push_waddr (mem_o_waddr),
        .push_wdata (mem_o_wdata),
        .full       (full),
        .empty      (empty),
        .rd_ptr     (rd_ptr),
        .ent_waddr  (ent_waddr),
        .ent_wdata  (ent_wdata),
        .ent_valid  (ent_valid)
    );

    // Writes to the zero register never enter the queue and never stall.
    assign push_req  = mem_o_wreg & (mem_o_waddr != AW'(ZERO_REG));
    assign rf_we     = ~empty;
    assign pop       = rf_we & rf_ready;
    assign push      = push_req & (~full | pop);
    assign stall_req = push_req & full & ~rf_ready;
    assign rf_waddr  = ent_waddr[rd_ptr];
    assign rf_wdata  = ent_wdata[rd_ptr];

    // Walk oldest to newest from the head so the newest live match wins.
    function automatic logic [DW-1:0] lookup(
        input logic [AW-1:0]             raddr,
        input logic [DW-1:0]             rf_data,
        input logic [DEPTH-1:0][AW-1:0]  wa,
        input logic [DEPTH-1:0][DW-1:0]  wd,
        input logic [DEPTH-1:0]          vld,
        input logic [PW-1:0]             rp
    );
        logic [DW-1:0] result;
        logic [PW-1:0] idx;
        result = rf_data;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rp + PW'(k);
            if (vld[idx] && (wa[idx] == raddr)) result = wd[idx];
        end
        if (raddr == AW'(ZERO_REG)) result = '0;
        return result;
    endfunction

    assign id_reg0 = lookup(id_raddr0, id_rf_data0, ent_waddr, ent_wdata, ent_valid, rd_ptr);
    assign id_reg1 = lookup(id_raddr1, id_rf_data1, ent_waddr, ent_wdata, ent_valid, rd_ptr);
endmodule
